// File: rtl/ide_timing_pkg.sv
// Shared state encoding, per-mode phase timing and mode clamping
// for the RIPPLE IDE PIO sequencer.
package ide_timing_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, ACTIVE, WAIT_END, HOLD, RECOVER} ide_state_t;

  // Phase lengths in CLK7M cycles: T1 setup, T2 strobe, TR recovery.
  localparam int unsigned T1_MODE0 = 1;
  localparam int unsigned T2_MODE0 = 3;
  localparam int unsigned TR_MODE0 = 2;
  localparam int unsigned T1_MODE1 = 1;
  localparam int unsigned T2_MODE1 = 2;
  localparam int unsigned TR_MODE1 = 1;
  localparam int unsigned T1_MODE2 = 1;
  localparam int unsigned T2_MODE2 = 1;
  localparam int unsigned TR_MODE2 = 1;

  // Down-counter load values (phase length - 1).
  typedef struct packed {
    logic [1:0] t1;
    logic [1:0] t2;
    logic [1:0] tr;
  } phase_load_t;

  function automatic logic [1:0] len_to_load(input int unsigned len);
    return 2'(len - 1);
  endfunction

  function automatic phase_load_t timing_of(input logic [1:0] m);
    phase_load_t t;
    case (m)
      2'd0:    t = '{t1: len_to_load(T1_MODE0), t2: len_to_load(T2_MODE0), tr: len_to_load(TR_MODE0)};
      2'd1:    t = '{t1: len_to_load(T1_MODE1), t2: len_to_load(T2_MODE1), tr: len_to_load(TR_MODE1)};
      default: t = '{t1: len_to_load(T1_MODE2), t2: len_to_load(T2_MODE2), tr: len_to_load(TR_MODE2)};
    endcase
    return t;
  endfunction

  function automatic logic [1:0] clamp_mode(input logic [2:0] req_mode, input int unsigned max_mode);
    int unsigned lim;
    int unsigned m;
    lim = (max_mode > 2) ? 2 : max_mode;
    m   = 32'(req_mode);
    return 2'((m > lim) ? lim : m);
  endfunction

endpackage

// File: rtl/ide_phase_counter.sv
// 2-bit loadable down-counter timing one sequencer phase; holds at zero.
module ide_phase_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [1:0] load_value,
  output logic [1:0] value,
  output logic       zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - 2'd1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/ide_pio_sequencer.sv
// Sequences one IDE PIO register cycle (setup/strobe/hold/recovery) per
// Zorro II request, driving both channels' chip selects and shared strobes.
module ide_pio_sequencer
  import ide_timing_pkg::*;
#(
  parameter int unsigned MAX_MODE = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       req,
  input  logic       rw,
  input  logic       port_sel,
  input  logic       cs_sel,
  input  logic       cfg_we,
  input  logic [2:0] cfg_mode,
  output logic [1:0] IDE1_CS_n,
  output logic [1:0] IDE2_CS_n,
  output logic       IOR_n,
  output logic       IOW_n,
  output logic       dtack,
  output logic       busy,
  output logic [1:0] mode
);

  ide_state_t  state, state_n;
  logic        rw_q, rw_n;
  logic [1:0]  sel_q, sel_n;
  logic [1:0]  t2_q, t2_n, tr_q, tr_n;
  logic        abort_q, abort_n;
  logic        start;
  phase_load_t tim_now;

  logic        cnt_load;
  logic [1:0]  cnt_load_value;
  logic [1:0]  cnt_value;
  logic        cnt_zero;

  logic        cs_on;
  logic [3:0]  cs_n_next;
  logic        ior_next, iow_next, dtack_next;

  ide_phase_counter u_phase_counter (
    .clk        (CLK),
    .rst        (RESET),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .value      (cnt_value),
    .zero       (cnt_zero)
  );

  always_comb begin
    state_n        = state;
    rw_n           = rw_q;
    sel_n          = sel_q;
    t2_n           = t2_q;
    tr_n           = tr_q;
    abort_n        = abort_q;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    tim_now        = timing_of(mode);
    // The final RECOVER clock doubles as the IDLE sampling point so a
    // back-to-back request starts exactly TR clocks after HOLD.
    start = req && (state == IDLE || (state == RECOVER && cnt_zero));

    case (state)
      IDLE: ;
      SETUP, ACTIVE: begin
        if (!req) begin
          state_n = HOLD;
          abort_n = 1'b1;
        end else if (cnt_zero) begin
          if (state == SETUP) begin
            state_n        = ACTIVE;
            cnt_load       = 1'b1;
            cnt_load_value = t2_q;
          end else begin
            state_n = rw_q ? WAIT_END : HOLD;
          end
        end
      end
      WAIT_END: begin
        if (!req) begin
          if (rw_q) begin
            state_n = HOLD;
          end else begin
            state_n        = RECOVER;
            cnt_load       = 1'b1;
            cnt_load_value = tr_q;
          end
        end
      end
      HOLD: begin
        if (rw_q || abort_q) begin
          state_n        = RECOVER;
          cnt_load       = 1'b1;
          cnt_load_value = tr_q;
        end else begin
          state_n = WAIT_END;
        end
      end
      RECOVER: if (cnt_zero) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (start) begin
      state_n        = SETUP;
      rw_n           = rw;
      sel_n          = {port_sel, cs_sel};
      t2_n           = tim_now.t2;
      tr_n           = tim_now.tr;
      abort_n        = 1'b0;
      cnt_load       = 1'b1;
      cnt_load_value = tim_now.t1;
    end

    cs_on      = state_n inside {SETUP, ACTIVE, WAIT_END, HOLD};
    cs_n_next  = cs_on ? ~(4'b0001 << sel_n) : '1;
    ior_next   = !(rw_n && (state_n == ACTIVE || state_n == WAIT_END));
    iow_next   = !(!rw_n && state_n == ACTIVE);
    dtack_next = (state_n == WAIT_END);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      rw_q      <= 1'b0;
      sel_q     <= '0;
      t2_q      <= '0;
      tr_q      <= '0;
      abort_q   <= 1'b0;
      mode      <= '0;
      IDE1_CS_n <= '1;
      IDE2_CS_n <= '1;
      IOR_n     <= 1'b1;
      IOW_n     <= 1'b1;
      dtack     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state   <= state_n;
      rw_q    <= rw_n;
      sel_q   <= sel_n;
      t2_q    <= t2_n;
      tr_q    <= tr_n;
      abort_q <= abort_n;
      if (cfg_we) mode <= clamp_mode(cfg_mode, MAX_MODE);
      {IDE2_CS_n, IDE1_CS_n} <= cs_n_next;
      IOR_n <= ior_next;
      IOW_n <= iow_next;
      dtack <= dtack_next;
      busy  <= (state_n != IDLE);
    end
  end

  a_strobe_len: assert property (@(posedge CLK) disable iff (RESET)
    (state == ACTIVE) |-> (cnt_value <= t2_q));

endmodule
